echo_canceller: RTL and testbench



---
 rtl/audio_fx_pkg.sv | 25 ++
 rtl/echo_canceller_if.sv | 22 ++
 rtl/mybram.sv | 26 ++
 rtl/echo_canceller.sv | 167 ++++++++++++++++
 tb/tb_echo_canceller.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the echo encoder/canceller pair: sample and address
// widths, the echo coefficient, FSM state encoding and the coefficient product.
package audio_fx_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int ADDR_W     = 13;
    localparam int DELAY_W    = 5;
    localparam int COEF_NUM   = 7;
    localparam int COEF_SHIFT = 3;
    localparam int PROD_W     = SAMPLE_W + COEF_SHIFT;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        FETCH  = 3'd2,
        SCALE  = 3'd3,
        OUTPUT = 3'd4
    } state_e;

    // Full-precision y*COEF_NUM; an arithmetic shift by COEF_SHIFT then floors it.
    function automatic logic signed [PROD_W-1:0] echo_product(input logic signed [SAMPLE_W-1:0] y);
        return PROD_W'(y) * PROD_W'(COEF_NUM);
    endfunction

endpackage

// File: rtl/echo_canceller_if.sv
// Sample-path handshake bundle shared by the echo stage and its canceller.
interface echo_canceller_if;
    import audio_fx_pkg::*;

    logic                       start;
    logic signed [SAMPLE_W-1:0] incoming_sample;
    logic [DELAY_W-1:0]         delay_amount;
    logic                       enable;
    logic signed [SAMPLE_W-1:0] modified_sample;
    logic                       done;

    modport master (
        output start, incoming_sample, delay_amount, enable,
        input  modified_sample, done
    );

    modport slave (
        input  start, incoming_sample, delay_amount, enable,
        output modified_sample, done
    );

endinterface

// File: rtl/mybram.sv
// Single-port block RAM with synchronous read; contents are never reset.
module mybram #(
    parameter int LOGSIZE = 13,
    parameter int WIDTH   = 12
) (
    input  logic               clk,
    input  logic [LOGSIZE-1:0] addr,
    input  logic [WIDTH-1:0]   din,
    input  logic               we,
    output logic [WIDTH-1:0]   dout
);

    logic [WIDTH-1:0] mem_q [0:(1<<LOGSIZE)-1];
    logic [WIDTH-1:0] dout_q;

    // Write port and registered read of the same address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/echo_canceller.sv
// Echo canceller: x[n] = y[n] + floor(7*y[n-m]/8), 12-bit wrapping, keeping the
// raw input history in a block RAM so it exactly inverts the echo stage.
module echo_canceller
    import audio_fx_pkg::*;
#(
    parameter int SAMPLING_RATE = 24000,
    parameter int SAMPLES       = 240
) (
    input  logic            clock,
    input  logic            reset_n,
    echo_canceller_if.slave bus
);

    if (SAMPLES * 31 >= (1 << ADDR_W) || SAMPLING_RATE <= 0) begin : g_bad_params
        $error("echo_canceller: SAMPLES*31 must be smaller than the history depth");
    end

    state_e                     state_q, state_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic signed [PROD_W-1:0]   scaled_q, scaled_d;
    logic signed [SAMPLE_W-1:0] modified_q, modified_d;
    logic                       done_q, done_d;
    logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]          prime_cnt_q, prime_cnt_d;
    logic [DELAY_W-1:0]         last_delay_q, last_delay_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [SAMPLE_W-1:0]        din_q, din_d;
    logic                       we_q, we_d;
    logic [SAMPLE_W-1:0]        dout_s;
    logic                       bypass_s;
    logic [ADDR_W-1:0]          delay_len_s;
    logic [ADDR_W-1:0]          prime_base_s;
    logic                       need_prime_s;

    // A delay change restarts priming for the very sample that carries it.
    assign bypass_s     = !bus.enable || (bus.delay_amount == {DELAY_W{1'b0}});
    assign delay_len_s  = ADDR_W'(SAMPLES) * ADDR_W'(bus.delay_amount);
    assign prime_base_s = (bus.delay_amount != last_delay_q) ? {ADDR_W{1'b0}} : prime_cnt_q;
    assign need_prime_s = prime_base_s < delay_len_s;

    mybram #(.LOGSIZE(ADDR_W), .WIDTH(SAMPLE_W)) history_ram (
        .clk  (clock),
        .addr (addr_q),
        .din  (din_q),
        .we   (we_q),
        .dout (dout_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; bypass forces IDLE and aborts any sample in flight.
    always_comb begin
        state_d = state_q;
        if (bypass_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = bus.start ? (need_prime_s ? PRIME : FETCH) : IDLE;
                PRIME:   state_d = IDLE;
                FETCH:   state_d = SCALE;
                SCALE:   state_d = OUTPUT;
                OUTPUT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output logic per state.
    always_comb begin
        sample_d     = sample_q;
        scaled_d     = scaled_q;
        modified_d   = modified_q;
        done_d       = done_q;
        wr_ptr_d     = wr_ptr_q;
        prime_cnt_d  = prime_cnt_q;
        last_delay_d = last_delay_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = 1'b0;
        if (bypass_s) begin
            modified_d = bus.incoming_sample;
            done_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sample_d     = bus.incoming_sample;
                        done_d       = 1'b0;
                        last_delay_d = bus.delay_amount;
                        if (need_prime_s) begin
                            prime_cnt_d = prime_base_s + ADDR_W'(1'b1);
                        end else begin
                            prime_cnt_d = prime_base_s;
                            addr_d      = wr_ptr_q - delay_len_s;
                        end
                    end else begin
                        done_d = done_q;
                    end
                end
                PRIME: begin
                    modified_d = sample_q;
                    addr_d     = wr_ptr_q;
                    din_d      = sample_q;
                    we_d       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1'b1);
                    done_d     = 1'b1;
                end
                FETCH: begin
                    scaled_d = scaled_q;
                end
                SCALE: begin
                    scaled_d = echo_product($signed(dout_s));
                end
                OUTPUT: begin
                    // History holds the raw echoed input, never the recovered output.
                    modified_d = sample_q + SAMPLE_W'(scaled_q >>> COEF_SHIFT);
                    addr_d     = wr_ptr_q;
                    din_d      = sample_q;
                    we_d       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1'b1);
                    done_d     = 1'b1;
                end
                default: begin
                    done_d = done_q;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_q     <= '0;
            scaled_q     <= '0;
            modified_q   <= '0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            prime_cnt_q  <= '0;
            last_delay_q <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            scaled_q     <= scaled_d;
            modified_q   <= modified_d;
            done_q       <= done_d;
            wr_ptr_q     <= wr_ptr_d;
            prime_cnt_q  <= prime_cnt_d;
            last_delay_q <= last_delay_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
        end
    end

    assign bus.modified_sample = modified_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_echo_canceller.sv
// Randomized bench for echo_canceller against a sample-level reference model,
// including a round trip through a behavioural echo encoder.
module tb_echo_canceller;
    import audio_fx_pkg::*;

    localparam int SAMPLES = 240;
    localparam int RT_N    = 8600;

    logic clock = 1'b0;
    logic reset_n;

    echo_canceller_if bus();

    echo_canceller #(.SAMPLING_RATE(24000), .SAMPLES(SAMPLES)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int hist[$];
    int enc_hist[$];
    int prime_cnt_m  = 0;
    int last_delay_m = 0;
    int last_fast;

    function automatic int wrap12(input int v);
        int r;
        r = v % 4096;
        if (r < 0) r += 4096;
        if (r >= 2048) r -= 4096;
        return r;
    endfunction

    function automatic int floor_div8(input int v);
        if (v >= 0) return v / 8;
        return -((-v + 7) / 8);
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: accepted active-mode sample -> expected output and latency.
    function automatic void model_accept(input int y, input int m, output int expv, output int lat);
        int d;
        d = SAMPLES * m;
        if (m != last_delay_m) begin
            prime_cnt_m  = 0;
            last_delay_m = m;
        end
        if (prime_cnt_m < d) begin
            prime_cnt_m++;
            expv = y;
            lat  = 1;
        end else begin
            expv = wrap12(y + floor_div8(7 * hist[hist.size() - d]));
            lat  = 3;
        end
        hist.push_back(y);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int y, input int m, input bit extra);
        int expv, lat;
        model_accept(y, m, expv, lat);
        bus.enable          = 1'b1;
        bus.delay_amount    = 5'(m);
        bus.incoming_sample = 12'(y);
        bus.start           = 1'b1;
        step();
        check_val("done_fall", int'(bus.done), 0);
        for (int k = 1; k <= 3; k++) begin
            bus.start           = (extra && k <= lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.incoming_sample = 12'($urandom);
            step();
            if (k == 1) last_fast = int'(bus.done);
            if (k == lat) begin
                check_val("sample_out", int'(bus.modified_sample), expv);
                check_val("done_rise", int'(bus.done), 1);
            end else if (k > lat) begin
                check_val("out_hold", int'(bus.modified_sample), expv);
            end else begin
                check_val("done_busy", int'(bus.done), 0);
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int v, x, y, n_prime;
        reset_n             = 1'b0;
        bus.start           = 1'b0;
        bus.enable          = 1'b1;
        bus.delay_amount    = 5'd1;
        bus.incoming_sample = 12'sd0;
        #12;
        check_val("reset_out", int'(bus.modified_sample), 0);
        check_val("reset_done", int'(bus.done), 0);
        reset_n = 1'b1;
        step();

        // Priming with fixed leading history for the echo corner cases.
        send(800, 1, 1'b0);
        send(-801, 1, 1'b0);
        send(2047, 1, 1'b0);
        for (int i = 3; i < 240; i++) send(rand_sample(), 1, 1'b0);
        send(100, 1, 1'b0);
        check_val("pos_echo", int'(bus.modified_sample), 800);
        send(0, 1, 1'b0);
        check_val("neg_floor", int'(bus.modified_sample), -701);
        send(2000, 1, 1'b0);
        check_val("wrap", int'(bus.modified_sample), -305);

        // Asynchronous reset while the next sample is in FETCH.
        bus.incoming_sample = 12'sd55;
        bus.start           = 1'b1;
        step();
        bus.start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_async_done", int'(bus.done), 0);
        check_val("rst_async_out", int'(bus.modified_sample), 0);
        step();
        reset_n      = 1'b1;
        prime_cnt_m  = 0;
        last_delay_m = 0;
        send(123, 1, 1'b0);
        check_val("reprime_fast", last_fast, 1);
        for (int i = 1; i < 240; i++) send(rand_sample(), 1, 1'b0);

        // Bypass by enable=0 then by delay_amount=0.
        for (int i = 0; i < 20; i++) begin
            v                   = rand_sample();
            bus.enable          = (i < 10) ? 1'b0 : 1'b1;
            bus.delay_amount    = (i < 10) ? 5'd1 : 5'd0;
            bus.incoming_sample = 12'(v);
            bus.start           = 1'($urandom_range(0, 1));
            step();
            check_val("bypass_out", int'(bus.modified_sample), v);
            check_val("bypass_done", int'(bus.done), 1);
        end
        bus.start        = 1'b0;
        bus.enable       = 1'b1;
        bus.delay_amount = 5'd1;
        for (int i = 0; i < 10; i++) send(rand_sample(), 1, 1'b0);

        // Enable falls during FETCH: the sample is dropped with no history write.
        bus.incoming_sample = 12'sd321;
        bus.start           = 1'b1;
        step();
        bus.start           = 1'b0;
        bus.enable          = 1'b0;
        v                   = rand_sample();
        bus.incoming_sample = 12'(v);
        step();
        check_val("abort_out", int'(bus.modified_sample), v);
        check_val("abort_done", int'(bus.done), 1);
        bus.enable = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send(rand_sample(), 1, 1'b0);

        // Delay change 1 -> 2 restarts priming for 480 samples.
        n_prime = 0;
        for (int i = 0; i < 500; i++) begin
            send(rand_sample(), 2, 1'b0);
            if (last_fast == 1) n_prime++;
        end
        check_val("prime_480", n_prime, 480);

        // Round trip through the echo encoder with ignored extra starts.
        for (int n = 0; n < RT_N; n++) begin
            x = rand_sample();
            if (n < SAMPLES * 31) y = x;
            else y = wrap12(x - floor_div8(7 * enc_hist[n - SAMPLES * 31]));
            enc_hist.push_back(y);
            send(y, 31, 1'b1);
            check_val("roundtrip", int'(bus.modified_sample), x);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
